uop_dispatch_ctrl: RTL and testbench
====================================

# uop_dispatch_ctrl

Controller that drains the micro-op queue and dispatches uop bundles to the reservation stations. Issues `get_uop` to the queue only when the queue holds uops and downstream credit covers a full bundle. Captures the bundle the queue returns one cycle later and holds it on a valid/ready issue port until accepted. Tracks per-slot credits returned by the backend and handles pipeline flushes.

## Interface
Parameters:
- `CREDITS`, default 16: reservation-station slots; initial and maximum credit count.
- `CW`, default `$clog2(CREDITS+1)`: width of the credit counter and of `credit_ret`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `q_elements` in `UOP::uop_size_t`: occupancy from the uop queue.
- `get_uop` out 1: dequeue request to the uop queue; combinational from state.
- `q_out_uop` in `UOP::uop_ins_t[0:OUT_UOP-1]`: bundle from the queue, valid the cycle after `get_uop`.
- `q_out_size` in `UOP::uop_size_t`: bundle size from the queue, same timing.
- `issue_valid` out 1: held bundle is valid.
- `issue_ready` in 1: backend accepts the bundle.
- `issue_uop` out `UOP::uop_ins_t[0:OUT_UOP-1]`: held bundle.
- `issue_size` out `UOP::uop_size_t`: number of valid uops in `issue_uop`.
- `credit_ret` in CW: slots freed by the backend this cycle.
- `flush` in 1: discard in-flight and held uops.
- `credits` out CW: current credit count.
- `issued_total` out 32: running count of uops issued; wraps.

## Operation
- States: IDLE, WAIT, HOLD, FLUSH.
- `fire` = `issue_valid && issue_ready`.
- `avail` = `credits` − (`fire` ? `issue_size` : 0).
- `can_fetch` = `q_elements` > 0 && `avail` ≥ OUT_UOP && !`flush`.
- `get_uop` = `can_fetch` && (state == IDLE || (state == HOLD && `fire`)).
- IDLE: if `can_fetch`, go to WAIT; otherwise stay.
- WAIT: register `q_out_uop` and `q_out_size` into the hold register, then go to HOLD. The queue does not clear `out_size`, so the data is trusted only in WAIT.
- HOLD: `issue_valid` = 1. On `fire`, go to WAIT if `get_uop`, else IDLE. Without `fire`, stay and keep the outputs stable.
- Credits update every cycle: `credits` ← `credits` − (`fire` ? `issue_size` : 0) + `credit_ret`. Consumption and return in the same cycle both apply.
- Credits saturate at CREDITS; reaching that clamp is a protocol error and must trip an assertion. Underflow is impossible by construction because fetch requires `avail` ≥ OUT_UOP.
- `issued_total` += `issue_size` on `fire`.
- `flush` from any state:
  - next state FLUSH; the held bundle is dropped and `issue_valid` goes 0 next cycle;
  - a bundle arriving during WAIT is not captured;
  - `fire` in the flush cycle still counts (credits and `issued_total` update);
  - `credits` is not reset, because the backend returns slots itself.
- FLUSH: `get_uop` = 0 for exactly one cycle, then IDLE. `flush` held high keeps the block in FLUSH.
- Reset values: state IDLE, `get_uop` 0, `issue_valid` 0, `issue_uop` all 0, `issue_size` 0, `credits` CREDITS, `issued_total` 0.

## Timing
- `get_uop` high in cycle N → queue data in N+1 → `issue_valid` in N+2. Minimum latency is 2 cycles.
- Back-to-back throughput: one bundle every 2 cycles. `get_uop` overlaps the `fire` cycle (HOLD→WAIT).
- `credit_ret` in cycle N is visible in `credits` at N+1 and usable for `can_fetch` in N+1.
- `reset` mid-operation takes priority over `flush` and everything else; all registers take their reset values at the next edge.
- `get_uop` is never high in WAIT or FLUSH, nor in HOLD without `fire`.

## Structure
- Shared package `UOP`: `uop_ins_t`, `uop_size_t`, `OUT_UOP`, `QU_UOP`.
- Add to `UOP`: a state enum `disp_state_t` {IDLE, WAIT, HOLD, FLUSH}.
- One natural sub-module, `uop_credit_counter`: CW-bit credit counter with consume, return and saturation.
- The FSM, hold register and `issued_total` live in the top.

## Test plan
Bench configuration: OUT_UOP=4, CREDITS=16.
- Reset, `q_elements`=0 → `get_uop` stays 0, `credits`=16, `issue_valid`=0 for 20 cycles.
- `q_elements`=6, `issue_ready`=1 → `get_uop` at cycles 0 and 2; bundles of size 4, then size 2; `credits`=10; `issued_total`=6.
- `issue_ready` low for 5 cycles in HOLD → `issue_uop`/`issue_size` stable, no `get_uop`; on accept, `credits` drops by `issue_size` exactly once.
- `credits`=4, fire size 4 with `credit_ret`=3 in the same cycle → `credits`=3; next `get_uop` only after `credits` ≥ 4.
- `flush` during WAIT → the arriving bundle is not captured, `issue_valid` stays 0, `get_uop` is 0 for the FLUSH cycle, fetch resumes from IDLE.
- `reset` asserted while in HOLD with `credits`=5 → next cycle: IDLE, `credits`=16, `issue_valid`=0, `issued_total`=0.

Source files
------------

// File: rtl/uop_dispatch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | UOP : shared uop types, bundle geometry and dispatch FSM states      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package UOP;
   localparam int OUT_UOP = 4;
   localparam int QU_UOP  = 16;

   typedef logic [31:0]                    uop_ins_t;
   typedef logic [$clog2(QU_UOP+1)-1:0]    uop_size_t;
   typedef uop_ins_t [0:OUT_UOP-1]         uop_bundle_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } disp_state_t;
endpackage
`default_nettype wire

// File: rtl/uop_dispatch_ctrl_credit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uop_credit_counter : reservation-station credits, consume/return/sat |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uop_credit_counter #(
   parameter int CREDITS = 16,
   parameter int CW      = $clog2(CREDITS+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] consume_i,
   input  logic [CW-1:0] return_i,
   output logic [CW-1:0] credits_o,
   output logic [CW-1:0] avail_o
);
   logic [CW-1:0] credits_q, credits_d;
   logic [CW:0]   w_sum;

   // avail cannot underflow: a bundle is only fetched when avail covers it
   always_comb begin
      avail_o   = credits_q - consume_i;
      w_sum     = {1'b0, avail_o} + {1'b0, return_i};
      credits_d = (w_sum > (CW+1)'(CREDITS)) ? CW'(CREDITS) : w_sum[CW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) credits_q <= CW'(CREDITS);
      else       credits_q <= credits_d;
   end

   assign credits_o = credits_q;

   a_no_credit_overflow: assert property (@(posedge clk) disable iff (reset)
      w_sum <= (CW+1)'(CREDITS));
endmodule
`default_nettype wire

// File: rtl/uop_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uop_dispatch_ctrl : drains the uop queue into a valid/ready issue port|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uop_dispatch_ctrl
   import UOP::*;
#(
   parameter int CREDITS = 16,
   parameter int CW      = $clog2(CREDITS+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  uop_size_t     q_elements,
   output logic          get_uop,
   input  uop_bundle_t   q_out_uop,
   input  uop_size_t     q_out_size,
   output logic          issue_valid,
   input  logic          issue_ready,
   output uop_bundle_t   issue_uop,
   output uop_size_t     issue_size,
   input  logic [CW-1:0] credit_ret,
   input  logic          flush,
   output logic [CW-1:0] credits,
   output logic [31:0]   issued_total
);
   disp_state_t   state_q, state_d;
   uop_bundle_t   hold_uop_q;
   uop_size_t     hold_size_q;
   logic [31:0]   total_q;

   logic          w_fire;
   logic          w_can_fetch;
   logic [CW-1:0] w_consume;
   logic [CW-1:0] w_avail;

   assign issue_valid = (state_q == HOLD);
   assign w_fire      = issue_valid && issue_ready;
   assign w_consume   = w_fire ? CW'(hold_size_q) : '0;

   uop_credit_counter #(
      .CREDITS (CREDITS),
      .CW      (CW)
   ) u_credit (
      .clk       (clk),
      .reset     (reset),
      .consume_i (w_consume),
      .return_i  (credit_ret),
      .credits_o (credits),
      .avail_o   (w_avail)
   );

   assign w_can_fetch = (q_elements != '0) && (w_avail >= CW'(OUT_UOP)) && !flush;

   always_comb begin
      state_d = state_q;
      get_uop = 1'b0;
      case (state_q)
         IDLE: begin
            get_uop = w_can_fetch;
            if (w_can_fetch) state_d = WAIT;
         end
         WAIT:  state_d = HOLD;
         HOLD: begin
            if (w_fire) begin
               get_uop = w_can_fetch;
               state_d = w_can_fetch ? WAIT : IDLE;
            end
         end
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = FLUSH;
   end

   // Queue output is only meaningful in WAIT; it is never cleared afterwards
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_uop_q  <= '0;
         hold_size_q <= '0;
         total_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WAIT && !flush) begin
            hold_uop_q  <= q_out_uop;
            hold_size_q <= q_out_size;
         end
         if (w_fire) total_q <= total_q + 32'(hold_size_q);
      end
   end

   assign issue_uop    = hold_uop_q;
   assign issue_size   = hold_size_q;
   assign issued_total = total_q;
endmodule
`default_nettype wire

// File: tb/tb_uop_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uop_dispatch_ctrl : directed + random bench with transaction model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uop_dispatch_ctrl;
   import UOP::*;

   localparam int CREDITS = 16;
   localparam int CW      = $clog2(CREDITS+1);

   logic          clk = 1'b0;
   logic          reset;
   uop_size_t     q_elements;
   logic          get_uop;
   uop_bundle_t   q_out_uop;
   uop_size_t     q_out_size;
   logic          issue_valid;
   logic          issue_ready;
   uop_bundle_t   issue_uop;
   uop_size_t     issue_size;
   logic [CW-1:0] credit_ret;
   logic          flush;
   logic [CW-1:0] credits;
   logic [31:0]   issued_total;

   always #5 clk = ~clk;

   uop_dispatch_ctrl #(.CREDITS(CREDITS), .CW(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .q_elements   (q_elements),
      .get_uop      (get_uop),
      .q_out_uop    (q_out_uop),
      .q_out_size   (q_out_size),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_uop    (issue_uop),
      .issue_size   (issue_size),
      .credit_ret   (credit_ret),
      .flush        (flush),
      .credits      (credits),
      .issued_total (issued_total)
   );

   typedef struct {
      uop_bundle_t u;
      int          sz;
   } bun_t;

   // Transaction model: bundles waiting at the issue port, one outstanding
   // fetch, a one-cycle post-flush blackout, plus credit/total bookkeeping.
   bun_t        held[$];
   bit          m_inflight;
   bit          m_block;
   bit          m_zero_out;
   bit          m_valid;
   int          m_credits;
   logic [31:0] m_total;

   // Queue emulation
   int          qcnt;
   bit          pend;
   bun_t        pend_b;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input bit rst, input bit rdy, input bit fl, input int ret_req);
      bit e_fire, e_get;
      int cons, avail, legal, ret, sz;
      bun_t cap;
      reset       = rst;
      issue_ready = rdy;
      flush       = fl;
      e_fire = (held.size() != 0) && rdy;
      cons   = e_fire ? held[0].sz : 0;
      legal  = CREDITS - m_credits + cons;
      ret    = (ret_req > legal) ? legal : ret_req;
      if (ret < 0) ret = 0;
      credit_ret = CW'(ret);
      q_elements = uop_size_t'(qcnt);
      if (pend) begin
         q_out_uop  = pend_b.u;
         q_out_size = uop_size_t'(pend_b.sz);
      end else begin
         for (int i = 0; i < OUT_UOP; i++) q_out_uop[i] = $urandom;
         q_out_size = uop_size_t'($urandom_range(0, OUT_UOP));
      end
      avail = m_credits - cons;
      e_get = (qcnt > 0) && (avail >= OUT_UOP) && !fl && !m_inflight && !m_block &&
              ((held.size() == 0) || e_fire);
      #1;
      if (m_valid) begin
         chk("get_uop", get_uop, e_get);
         chk("issue_valid", issue_valid, held.size() != 0);
         chk("credits", credits, m_credits);
         chk("issued_total", issued_total, m_total);
         if (held.size() != 0) begin
            chk("issue_size", issue_size, held[0].sz);
            chk("issue_uop", issue_uop, held[0].u);
         end else if (m_zero_out) begin
            chk("issue_size_rst", issue_size, 0);
            chk("issue_uop_rst", issue_uop, 0);
         end
      end
      cap.u  = q_out_uop;
      cap.sz = int'(q_out_size);
      @(posedge clk);
      if (rst) begin
         held.delete();
         m_inflight = 0;
         m_block    = 0;
         m_zero_out = 1;
         m_valid    = 1;
         m_credits  = CREDITS;
         m_total    = '0;
         pend       = 0;
      end else begin
         m_credits = m_credits - cons + ret;
         if (m_credits > CREDITS) m_credits = CREDITS;
         m_total = m_total + 32'(cons);
         if (e_fire) void'(held.pop_front());
         if (fl) begin
            held.delete();
            m_inflight = 0;
            m_block    = 1;
         end else begin
            if (m_inflight) begin
               held.push_back(cap);
               m_zero_out = 0;
            end
            m_inflight = e_get;
            m_block    = 0;
         end
         pend = e_get;
         if (e_get) begin
            sz = (qcnt < OUT_UOP) ? qcnt : OUT_UOP;
            qcnt -= sz;
            pend_b.sz = sz;
            for (int i = 0; i < OUT_UOP; i++) pend_b.u[i] = $urandom;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b1;
      issue_ready = 1'b0;
      flush       = 1'b0;
      credit_ret  = '0;
      q_elements  = '0;
      q_out_uop   = '0;
      q_out_size  = '0;
      m_valid     = 0;
      m_credits   = CREDITS;
      m_total     = '0;
      qcnt        = 0;
      pend        = 0;
      @(negedge clk);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);

      // Idle with an empty queue
      repeat (20) tick(0, 1, 0, 0);
      chk("t1_credits", credits, 16);

      // Six uops: bundles of 4 then 2, back to back
      qcnt = 6;
      repeat (8) tick(0, 1, 0, 0);
      chk("t2_credits", credits, 10);
      chk("t2_total", issued_total, 6);

      // Backpressure in HOLD for several cycles
      qcnt = 4;
      repeat (7) tick(0, 0, 0, 0);
      chk("t3_hold", issue_valid, 1);
      repeat (2) tick(0, 1, 0, 0);
      chk("t3_credits", credits, 6);

      // Simultaneous consume and return
      qcnt = 2;
      repeat (4) tick(0, 1, 0, 0);
      chk("t4_credits_pre", credits, 4);
      qcnt = 8;
      for (int i = 0; i < 10 && held.size() == 0; i++) tick(0, 1, 0, 0);
      chk("t4_in_hold", issue_valid, 1);
      tick(0, 1, 0, 3);
      chk("t4_credits", credits, 3);
      repeat (4) tick(0, 1, 0, 0);
      tick(0, 1, 0, 1);
      tick(0, 1, 0, 0);
      repeat (3) tick(0, 1, 0, 16);

      // Flush during WAIT, flush held for two cycles
      qcnt = 8;
      for (int i = 0; i < 10 && !m_inflight; i++) tick(0, 1, 0, 0);
      tick(0, 1, 1, 0);
      tick(0, 1, 1, 0);
      chk("t5_no_valid", issue_valid, 0);
      repeat (6) tick(0, 1, 0, 2);

      // Reset while holding a bundle
      qcnt = 4;
      for (int i = 0; i < 10 && held.size() == 0; i++) tick(0, 0, 0, 0);
      chk("t6_in_hold", issue_valid, 1);
      tick(1, 0, 0, 0);
      #1;
      chk("t6_valid", issue_valid, 0);
      chk("t6_credits", credits, 16);
      chk("t6_total", issued_total, 0);

      // Randomized traffic
      repeat (400) begin
         if (qcnt < 3 && ($urandom % 4) == 0)
            qcnt = qcnt + $urandom_range(1, 8);
         if (qcnt > QU_UOP) qcnt = QU_UOP;
         tick(0, ($urandom % 10) < 7, ($urandom % 20) == 0, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
